// File: rtl/dmem_mailbox_responder_if.sv
// Core data-memory bus: store strobe, byte address, store data, byte lanes.
// master = core side (drives stores), slave = memory side (returns load data).
interface dmem_mailbox_responder_if;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic [3:0]  byte_en;
    logic [31:0] read_data;

    modport master (
        output mem_write,
        output data_adr,
        output write_data,
        output byte_en,
        input  read_data
    );

    modport slave (
        input  mem_write,
        input  data_adr,
        input  write_data,
        input  byte_en,
        output read_data
    );
endinterface

// File: rtl/dmem_mailbox_responder.sv
// Data-memory responder: word RAM plus a PASS/FAIL mailbox and cycle timeout
// that end a self-checking program run on the core.
//
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous, active-low reset
//   bus          slave side of the core store/load bus
//                (mem_write, data_adr, write_data, byte_en in; read_data out,
//                 combinational from data_adr)
//   done         program finished (PASS, FAIL or TIMEOUT)
//   pass         mailbox received PASS_VALUE
//   fail         FAIL or TIMEOUT
//   timeout      cycle budget exhausted
//   store_count  accepted stores since reset, saturating at 16'hFFFF
//
// Optional feature: define DMEM_STRICT_ALIGN_EN to turn misaligned word and
// halfword stores into a FAIL. Without it data_adr[1:0] is ignored for RAM.
module dmem_mailbox_responder #(
    parameter int unsigned DEPTH_WORDS    = 64,
    parameter int unsigned MAILBOX_ADDR   = 100,
    parameter int unsigned PASS_VALUE     = 25,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mailbox_responder_if.slave bus,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_count
);

    localparam int          ADDR_W   = $clog2(4 * DEPTH_WORDS);
    localparam int          WIDX_W   = ADDR_W - 2;
    localparam logic [31:0] RAM_SIZE = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] MBOX_A   = 32'(MAILBOX_ADDR);
    localparam logic [31:0] PASS_W   = 32'(PASS_VALUE);
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TMO
    } state_t;

    state_t      state;
    logic [31:0] cyc;
    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic              accept;
    logic              is_mbox;
    logic              in_rng;
    logic              misalign;
    logic              mbox_pass;
    logic              mbox_fail;
    logic              bad_store;
    logic              ram_we;
    logic              tmo_hit;
    logic [WIDX_W-1:0] widx;

    assign widx    = bus.data_adr[ADDR_W-1:2];
    assign accept  = bus.mem_write && (state == S_RUN);
    assign is_mbox = (bus.data_adr == MBOX_A);
    assign in_rng  = (bus.data_adr < RAM_SIZE);

`ifdef DMEM_STRICT_ALIGN_EN
    // Full words need a 4-byte aligned address, halfword lane pairs an
    // even one; other lane patterns are treated as byte stores.
    always_comb begin
        misalign = 1'b0;
        if (bus.byte_en == 4'hF)
            misalign = (bus.data_adr[1:0] != 2'b00);
        else if (bus.byte_en == 4'b0011 || bus.byte_en == 4'b1100)
            misalign = bus.data_adr[0];
    end
`else
    assign misalign = 1'b0;
`endif

    assign mbox_pass = is_mbox && (bus.byte_en == 4'hF)
                       && (bus.write_data == PASS_W);
    assign mbox_fail = is_mbox && !mbox_pass;
    // Mailbox decode takes priority over the RAM range check.
    assign bad_store = !is_mbox && (!in_rng || misalign);
    assign ram_we    = accept && !is_mbox && in_rng && !misalign;
    assign tmo_hit   = TMO_EN && (cyc == TMO_LAST);

    // Loads: mailbox status, RAM word, or zero when out of range.
    always_comb begin
        bus.read_data = 32'h0;
        if (is_mbox)
            bus.read_data = {29'b0, timeout, fail, pass};
        else if (in_rng)
            bus.read_data = mem[widx];
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byte_en[i])
                    mem[widx][8*i +: 8] <= bus.write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            store_count <= 16'h0;
            cyc         <= 32'h0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (accept && store_count != 16'hFFFF)
                        store_count <= store_count + 16'd1;
                    // A terminal store on the timeout edge wins.
                    if (accept && mbox_pass) begin
                        state <= S_PASS;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (accept && (mbox_fail || bad_store)) begin
                        state <= S_FAIL;
                        done  <= 1'b1;
                        fail  <= 1'b1;
                    end else if (tmo_hit) begin
                        state   <= S_TMO;
                        done    <= 1'b1;
                        fail    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (TMO_EN) begin
                        cyc <= cyc + 32'd1;
                    end
                end
                S_PASS, S_FAIL, S_TMO: begin
                end
            endcase
        end
    end

endmodule
